alu_seq: RTL and testbench

Parametrised, handshaked successor of the single-cycle datapath ALU. It executes the 4-bit operation set on WIDTH-bit operands. Logic, add/sub, compare, shift and LUI operations complete in one cycle. MUL runs as an iterative shift-add multiplier, and DIVU runs as a restoring divider. It sits between decode/issue and writeback, and the valid/ready pair lets the pipeline stall on multi-cycle ops.

---
 rtl/alu_seq.sv | 203 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-cycle ALU.
// Single-cycle ops (logic, add/sub, compares, shifts, LUI) finish the cycle after acceptance.
// MUL is an iterative shift-add multiplier (one multiplier bit per cycle, LSB first).
// DIVU is a restoring divider (one quotient bit per cycle), built only when ALU_DIV_EN
// is defined; otherwise DIVU completes at once with result 0 and illegal_o set.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   in_valid_i / in_ready_o  request handshake (ready only while idle)
//   ctrl_i                   4-bit opcode
//   src1_i, src2_i, shamt_i  operands and immediate shift amount
//   out_valid_o/out_ready_i  result handshake (result held until consumed)
//   result_o, zero_o         registered result and its zero flag
//   illegal_o                op not supported in this build (qualified by out_valid_o)
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             illegal_o
);

  localparam logic [3:0] OpAnd  = 4'd0;
  localparam logic [3:0] OpOr   = 4'd1;
  localparam logic [3:0] OpLw   = 4'd2;
  localparam logic [3:0] OpSw   = 4'd3;
  localparam logic [3:0] OpAddu = 4'd4;
  localparam logic [3:0] OpSubu = 4'd5;
  localparam logic [3:0] OpSlt  = 4'd6;
  localparam logic [3:0] OpBlez = 4'd7;
  localparam logic [3:0] OpSra  = 4'd8;
  localparam logic [3:0] OpSrav = 4'd9;
  localparam logic [3:0] OpLui  = 4'd10;
  localparam logic [3:0] OpSltu = 4'd11;
  localparam logic [3:0] OpSll  = 4'd12;
  localparam logic [3:0] OpMul  = 4'd13;
  localparam logic [3:0] OpBgtz = 4'd14;
  localparam logic [3:0] OpDivu = 4'd15;

  localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  // a: multiplier (shifts right) / dividend-then-quotient (shifts left)
  // b: multiplicand (shifts left) / divisor
  // acc: product accumulator / partial remainder
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ill_q, ill_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] mul_acc;

  // Single-cycle result from the live inputs; only sampled on the accept edge.
  always_comb begin
    alu_res = '0;
    unique case (ctrl_i)
      OpAnd:               alu_res = src1_i & src2_i;
      OpOr:                alu_res = src1_i | src2_i;
      OpLw, OpSw, OpAddu:  alu_res = src1_i + src2_i;
      OpSubu:              alu_res = src1_i - src2_i;
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
      OpBlez:  alu_res = {{(WIDTH-1){1'b0}}, (src1_i[WIDTH-1] | (src1_i == '0))};
      OpBgtz:  alu_res = {{(WIDTH-1){1'b0}}, (~src1_i[WIDTH-1] & (src1_i != '0))};
      OpSra:   alu_res = WIDTH'($signed(src2_i) >>> shamt_i);
      OpSrav:  alu_res = WIDTH'($signed(src2_i) >>> src1_i[SHW-1:0]);
      OpSll:   alu_res = src2_i << shamt_i;
      OpLui:   alu_res = {src2_i[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: alu_res = '0;  // MUL/DIVU are produced by the iterative paths
    endcase
  end

  assign mul_acc = a_q[0] ? (acc_q + b_q) : acc_q;

`ifdef ALU_DIV_EN
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_qbit;
  logic [WIDTH-1:0] div_rem;

  // Remainder is always < divisor, so one extra bit holds the shifted value.
  assign div_shift = {acc_q, a_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_qbit  = (div_shift >= {1'b0, b_q});
  assign div_rem   = div_qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ill_d   = ill_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          a_d   = src1_i;
          b_d   = src2_i;
          acc_d = '0;
          cnt_d = '0;
          if (ctrl_i == OpMul) begin
            state_d = StMul;
          end else if (ctrl_i == OpDivu) begin
`ifdef ALU_DIV_EN
            state_d = StDiv;
`else
            res_d   = '0;
            zero_d  = 1'b1;
            ill_d   = 1'b1;
            state_d = StDone;
`endif
          end else begin
            res_d   = alu_res;
            zero_d  = (alu_res == '0);
            ill_d   = 1'b0;
            state_d = StDone;
          end
        end
      end
      StMul: begin
        acc_d = mul_acc;
        a_d   = a_q >> 1;
        b_d   = b_q << 1;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          res_d   = mul_acc;
          zero_d  = (mul_acc == '0);
          ill_d   = 1'b0;
          state_d = StDone;
        end
      end
`ifdef ALU_DIV_EN
      StDiv: begin
        acc_d = div_rem;
        a_d   = {a_q[WIDTH-2:0], div_qbit};
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          res_d   = {a_q[WIDTH-2:0], div_qbit};
          zero_d  = ({a_q[WIDTH-2:0], div_qbit} == '0);
          ill_d   = 1'b0;
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign result_o    = res_q;
  assign zero_o      = zero_q;
  assign illegal_o   = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq at WIDTH=32 with hand-computed expectations.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  ctrl = '0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .ctrl_i     (ctrl),
    .src1_i     (src1),
    .src2_i     (src2),
    .shamt_i    (shamt),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result),
    .zero_o     (zero),
    .illegal_o  (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op, count edges from the accept edge (inclusive) until out_valid,
  // check the result, then consume it.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp,
                        input int exp_lat, input logic exp_ill);
    int   lat;
    logic busy_ok;
    @(negedge clk);
    ctrl = op; src1 = a; src2 = b; shamt = sh; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; src1 = ~a; src2 = ~b; shamt = ~sh;  // operands must be frozen
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_res"}, result, exp);
    check({tag, "_zero"}, 32'(zero), 32'(exp == 32'd0));
    check({tag, "_ill"}, 32'(illegal), 32'(exp_ill));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_consumed"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    #12;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_ill", 32'(illegal), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("addu", 4'd4, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0000_0000, 1, 1'b0);
    run_op("subu", 4'd5, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE, 1, 1'b0);
    run_op("slt", 4'd6, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1, 1'b0);
    run_op("sltu", 4'd11, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1, 1'b0);
    run_op("sra", 4'd8, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1, 1'b0);
    run_op("lui", 4'd10, 32'd0, 32'h0000_1234, 5'd0, 32'h1234_0000, 1, 1'b0);
    run_op("and", 4'd0, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_F000, 1, 1'b0);
    run_op("or", 4'd1, 32'h0000_F0F0, 32'h0000_0F0F, 5'd0, 32'h0000_FFFF, 1, 1'b0);
    run_op("lw", 4'd2, 32'd8, 32'd4, 5'd0, 32'd12, 1, 1'b0);
    run_op("srav", 4'd9, 32'h0000_0021, 32'h8000_0000, 5'd0, 32'hC000_0000, 1, 1'b0);
    run_op("sll", 4'd12, 32'd0, 32'd1, 5'd31, 32'h8000_0000, 1, 1'b0);
    run_op("blez0", 4'd7, 32'd0, 32'd0, 5'd0, 32'd1, 1, 1'b0);
    run_op("bgtz0", 4'd14, 32'd0, 32'd0, 5'd0, 32'd0, 1, 1'b0);
    run_op("bgtz5", 4'd14, 32'd5, 32'd0, 5'd0, 32'd1, 1, 1'b0);
    run_op("mul", 4'd13, 32'h0001_0003, 32'h0002_0005, 5'd0, 32'h000B_000F, 33, 1'b0);
    run_op("mulneg", 4'd13, 32'hFFFF_FFFF, 32'd3, 5'd0, 32'hFFFF_FFFD, 33, 1'b0);
`ifdef ALU_DIV_EN
    run_op("divu", 4'd15, 32'd100, 32'd7, 5'd0, 32'd14, 33, 1'b0);
    run_op("divu0", 4'd15, 32'd5, 32'd0, 5'd0, 32'hFFFF_FFFF, 33, 1'b0);
`else
    run_op("divu_ill", 4'd15, 32'd100, 32'd7, 5'd0, 32'd0, 1, 1'b1);
`endif

    // Backpressure: result held for 10 cycles while a new request is offered.
    @(negedge clk);
    ctrl = 4'd4; src1 = 32'd3; src2 = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    ctrl = 4'd1; src1 = 32'h0000_00F0; src2 = 32'h0000_000F;  // stays offered
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {result[29:0], out_valid, in_ready}, {30'd7, 1'b1, 1'b0});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", 32'({out_valid, in_ready}), 32'b01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_res", result, 32'h0000_00FF);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during MUL iteration 12 discards the operation.
    @(negedge clk);
    ctrl = 4'd13; src1 = 32'd6; src2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op("mul_after_rst", 4'd13, 32'd6, 32'd7, 5'd0, 32'd42, 33, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
